// File: rtl/result_logger_pkg.sv
// Shared definitions for the result logger: default geometry, the ioports
// bit assignments used to drive the logger, and the P5in status packing.
package result_logger_pkg;

    localparam int DEF_NCH  = 4;
    localparam int DEF_DW   = 16;
    localparam int DEF_AW   = 6;
    localparam int DEF_DECW = 8;

    localparam int RD_WORD_W = 32;
    localparam int CHAN_W    = 3;
    localparam int OVF_W     = 16;

    // ioports command interpreter map: P0out[1]=enable, P0out[2]=clear,
    // P1out carries decim, PFout[0] is the read-advance strobe.
    localparam int P0_ENABLE_BIT   = 1;
    localparam int P0_CLEAR_BIT    = 2;
    localparam int PF_RDSTROBE_BIT = 0;

    // P5in status word layout, MSB first: {ovf_cnt, level, full, empty, rd_chan}
    typedef struct packed {
        logic [OVF_W-1:0]  ovf_cnt;
        logic [DEF_AW:0]   level;
        logic              full;
        logic              empty;
        logic [CHAN_W-1:0] rd_chan;
    } status_t;

    function automatic status_t pack_status(
        input logic [OVF_W-1:0]  ovf_cnt,
        input logic [DEF_AW:0]   level,
        input logic              full,
        input logic              empty,
        input logic [CHAN_W-1:0] rd_chan
    );
        status_t s;
        s.ovf_cnt = ovf_cnt;
        s.level   = level;
        s.full    = full;
        s.empty   = empty;
        s.rd_chan = rd_chan;
        return s;
    endfunction

endpackage

// File: rtl/logger_ram.sv
// Record store for the result logger: one full record written per cycle,
// one channel word read per cycle through an output register that can be
// forced to zero (empty FIFO, clear, reset).
module logger_ram
    import result_logger_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int CW  = 2
) (
    input  logic                clock,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [NCH*DW-1:0]   wdata_i,
    input  logic [AW-1:0]       raddr_i,
    input  logic [CW-1:0]       rchan_i,
    input  logic                rzero_i,
    output logic [DW-1:0]       rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [NCH-1:0][DW-1:0] mem_q [DEPTH];
    logic [DW-1:0]          rdata_q;

    // Whole-record write; no reset so the array maps onto RAM primitives.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered word read; the zero override acts like a RAM output reset.
    always_ff @(posedge clock) begin
        if (rzero_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i][rchan_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/result_logger.sv
// Decimating capture FIFO for multi-channel measurement results, drained
// one sign-extended channel word at a time by the host.
module result_logger
    import result_logger_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int DECW = DEF_DECW
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DECW-1:0]      decim,
    input  logic                 clear,
    input  logic                 in_strobe,
    input  logic [NCH*DW-1:0]    in_data,
    input  logic                 rd_strobe,
    output logic [RD_WORD_W-1:0] rd_data,
    output logic [CHAN_W-1:0]    rd_chan,
    output logic [AW:0]          level,
    output logic                 empty,
    output logic                 full,
    output logic [OVF_W-1:0]     ovf_cnt
);

    localparam int             CW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW:0]    FULL_LEVEL = {1'b1, {AW{1'b0}}};
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NCH - 1);

    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       level_q, level_d;
    logic [DECW-1:0]   dc_q, dc_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic              empty_q, full_q;

    logic              accept;
    logic              advance;
    logic              pop;
    logic              write;
    logic              drop;
    logic [DW-1:0]     ram_word;

    // Decimation, FIFO bookkeeping and read cursor; clear overrides it all.
    always_comb begin
        accept = 1'b0;
        dc_d   = dc_q;
        if (enable && in_strobe) begin
            if (dc_q == '0) begin
                accept = 1'b1;
                dc_d   = decim;
            end else begin
                dc_d = dc_q - DECW'(1);
            end
        end

        advance = rd_strobe && !empty_q;
        pop     = advance && (chan_q == LAST_CHAN);
        write   = accept && (!full_q || pop);
        drop    = accept && full_q && !pop;

        wptr_d = write ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;

        chan_d = chan_q;
        if (advance) begin
            chan_d = pop ? '0 : chan_q + CHAN_W'(1);
        end

        level_d = level_q;
        if (write && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop && !write) begin
            level_d = level_q - (AW+1)'(1);
        end

        ovf_d = (drop && (ovf_q != '1)) ? ovf_q + OVF_W'(1) : ovf_q;

        if (clear) begin
            write   = 1'b0;
            dc_d    = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            chan_d  = '0;
            level_d = '0;
            ovf_d   = '0;
        end
    end

    // State registers; empty/full are registered so no output decodes level.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            dc_q    <= '0;
            ovf_q   <= '0;
            chan_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            dc_q    <= dc_d;
            ovf_q   <= ovf_d;
            chan_q  <= chan_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == FULL_LEVEL);
        end
    end

    logger_ram #(
        .NCH (NCH),
        .DW  (DW),
        .AW  (AW),
        .CW  (CW)
    ) u_ram (
        .clock   (clock),
        .we_i    (write && !reset),
        .waddr_i (wptr_q),
        .wdata_i (in_data),
        .raddr_i (rptr_q),
        .rchan_i (chan_q[CW-1:0]),
        .rzero_i (reset || clear || empty_q),
        .rdata_o (ram_word)
    );

    assign rd_data = RD_WORD_W'(signed'(ram_word));
    assign rd_chan = chan_q;
    assign level   = level_q;
    assign empty   = empty_q;
    assign full    = full_q;
    assign ovf_cnt = ovf_q;

endmodule
